// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sharing of the single-port data memory between
// the LSU (r0) and the debug/DMA loader (r1), one outstanding access at a time.
module data_mem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_AW        = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_r0_req_valid,
    output logic                     o_r0_req_ready,
    input  logic                     i_r0_we,
    input  logic                     i_r0_byte,
    input  logic [ADDRESS_WIDTH-1:0] i_r0_addr,
    input  logic [DATA_WIDTH-1:0]    i_r0_wdata,
    output logic                     o_r0_rsp_valid,
    input  logic                     i_r0_rsp_ready,
    output logic [DATA_WIDTH-1:0]    o_r0_rdata,
    output logic                     o_r0_err,
    input  logic                     i_r1_req_valid,
    output logic                     o_r1_req_ready,
    input  logic                     i_r1_we,
    input  logic                     i_r1_byte,
    input  logic [ADDRESS_WIDTH-1:0] i_r1_addr,
    input  logic [DATA_WIDTH-1:0]    i_r1_wdata,
    output logic                     o_r1_rsp_valid,
    input  logic                     i_r1_rsp_ready,
    output logic [DATA_WIDTH-1:0]    o_r1_rdata,
    output logic                     o_r1_err,
    output logic                     o_mem_we,
    output logic                     o_mem_addr_mode,
    output logic [ADDRESS_WIDTH-1:0] o_mem_a,
    output logic [DATA_WIDTH-1:0]    o_mem_wd,
    input  logic [DATA_WIDTH-1:0]    i_mem_rd
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t                  r_state;
    logic                    r_last_grant;
    logic                    r_owner;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                     w_grant;
    logic                     w_accept;
    logic                     w_we;
    logic                     w_byte;
    logic [ADDRESS_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]    w_wdata;
    logic                     w_err;
    logic                     w_rsp_ready;
    logic                     w_resp;

    // on contention the requester that did not win last time gets the grant
    assign w_grant  = (i_r0_req_valid & i_r1_req_valid) ? ~r_last_grant : i_r1_req_valid;
    assign w_accept = (r_state == S_IDLE) & (i_r0_req_valid | i_r1_req_valid);
    assign o_r0_req_ready = w_accept & ~w_grant;
    assign o_r1_req_ready = w_accept & w_grant;

    assign w_we    = w_grant ? i_r1_we    : i_r0_we;
    assign w_byte  = w_grant ? i_r1_byte  : i_r0_byte;
    assign w_addr  = w_grant ? i_r1_addr  : i_r0_addr;
    assign w_wdata = w_grant ? i_r1_wdata : i_r0_wdata;
    assign w_err   = (~w_byte & (|w_addr[1:0])) | (|w_addr[ADDRESS_WIDTH-1:MEM_AW]);

    assign w_resp      = (r_state == S_RESP);
    assign w_rsp_ready = r_owner ? i_r1_rsp_ready : i_r0_rsp_ready;

    assign o_r0_rsp_valid = w_resp & ~r_owner;
    assign o_r1_rsp_valid = w_resp & r_owner;
    assign o_r0_rdata     = r_rdata;
    assign o_r1_rdata     = r_rdata;
    assign o_r0_err       = o_r0_rsp_valid & r_err;
    assign o_r1_err       = o_r1_rsp_valid & r_err;

    // the memory pins are loaded at accept so they already carry the access during ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_last_grant    <= 1'b1;
            r_owner         <= 1'b0;
            r_err           <= 1'b0;
            r_rdata         <= '0;
            o_mem_we        <= 1'b0;
            o_mem_addr_mode <= 1'b0;
            o_mem_a         <= '0;
            o_mem_wd        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        if (w_err) begin
                            r_state <= S_RESP;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_state         <= S_ACCESS;
                            o_mem_we        <= w_we;
                            o_mem_addr_mode <= w_byte;
                            o_mem_a         <= w_addr;
                            o_mem_wd        <= w_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    r_state  <= S_RESP;
                    r_err    <= 1'b0;
                    o_mem_we <= 1'b0;
                    r_rdata  <= o_mem_we ? '0 :
                                o_mem_addr_mode ? {{(DATA_WIDTH-8){1'b0}}, i_mem_rd[7:0]} : i_mem_rd;
                end
                S_RESP: begin
                    if (w_rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench with a byte-array reference memory and a
// separate physical memory model driven only by the DUT's memory pins.
module tb_data_mem_arbiter;
    localparam int MSZ = 1 << 17;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 1;
    logic [1:0]  req_v = '0, req_rdy, we = '0, byt = '0, rsp_v, rsp_rdy = 2'b11, err;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        mem_we, mem_mode;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [7:0]  phys [0:MSZ+3];
    logic [7:0]  refm [0:MSZ-1];
    exp_t        q [2][$];
    int          gq [$];
    int          tests = 0, fails = 0, cyc = 0, last = 1, wr_cnt = 0, exp_wr = 0;
    bit          sb_off = 0;
    bit   [1:0]  held = '0;
    logic [31:0] hd [2];
    logic [1:0]  he;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_r0_req_valid(req_v[0]), .o_r0_req_ready(req_rdy[0]), .i_r0_we(we[0]), .i_r0_byte(byt[0]),
        .i_r0_addr(addr[0]), .i_r0_wdata(wdata[0]), .o_r0_rsp_valid(rsp_v[0]), .i_r0_rsp_ready(rsp_rdy[0]),
        .o_r0_rdata(rdata[0]), .o_r0_err(err[0]),
        .i_r1_req_valid(req_v[1]), .o_r1_req_ready(req_rdy[1]), .i_r1_we(we[1]), .i_r1_byte(byt[1]),
        .i_r1_addr(addr[1]), .i_r1_wdata(wdata[1]), .o_r1_rsp_valid(rsp_v[1]), .i_r1_rsp_ready(rsp_rdy[1]),
        .o_r1_rdata(rdata[1]), .o_r1_err(err[1]),
        .o_mem_we(mem_we), .o_mem_addr_mode(mem_mode), .o_mem_a(mem_a), .o_mem_wd(mem_wd), .i_mem_rd(mem_rd)
    );

    // little-endian byte memory, combinational read, write on the clock edge
    always @(posedge clk)
        if (mem_we && mem_a < MSZ) begin
            phys[int'(mem_a[16:0])] <= mem_wd[7:0];
            if (!mem_mode) begin
                phys[int'(mem_a[16:0]) + 1] <= mem_wd[15:8];
                phys[int'(mem_a[16:0]) + 2] <= mem_wd[23:16];
                phys[int'(mem_a[16:0]) + 3] <= mem_wd[31:24];
            end
        end

    always @* begin
        mem_rd = '0;
        if (mem_a < MSZ)
            mem_rd = {phys[int'(mem_a[16:0]) + 3], phys[int'(mem_a[16:0]) + 2],
                      phys[int'(mem_a[16:0]) + 1], phys[int'(mem_a[16:0])]};
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic ref_access(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output logic e);
        e  = (!b && a[1:0] != 2'b00) || a >= MSZ;
        rd = '0;
        if (!e) begin
            if (w) begin
                exp_wr++;
                refm[a] = d[7:0];
                if (!b) begin
                    refm[a + 1] = d[15:8];
                    refm[a + 2] = d[23:16];
                    refm[a + 3] = d[31:24];
                end
            end else begin
                rd = b ? {24'h0, refm[a]} : {refm[a + 3], refm[a + 2], refm[a + 1], refm[a]};
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q[0].delete();
            q[1].delete();
            last = 1;
            held = '0;
        end else begin
            chk("both_req_ready", {31'b0, req_rdy[0] & req_rdy[1]}, 0);
            chk("both_rsp_valid", {31'b0, rsp_v[0] & rsp_v[1]}, 0);
            for (int k = 0; k < 2; k++)
                if (req_v[k] && req_rdy[k]) begin
                    exp_t e;
                    if (req_v == 2'b11) chk("rr_grant", k, 1 - last);
                    last = k;
                    gq.push_back(k);
                    if (!sb_off) begin
                        ref_access(we[k], byt[k], addr[k], wdata[k], e.rdata, e.err);
                        e.cyc = cyc + (e.err ? 1 : 2);
                        q[k].push_back(e);
                    end
                end
            if (mem_we && !sb_off) begin
                wr_cnt++;
                chk("mem_a_range", {31'b0, mem_a < MSZ}, 1);
            end
            for (int k = 0; k < 2; k++)
                if (rsp_v[k]) begin
                    if (q[k].size() == 0) chk("rsp_unexpected", 1, 0);
                    else begin
                        if (!held[k]) chk("rsp_latency", cyc, q[k][0].cyc);
                        else begin
                            chk("hold_rdata", rdata[k], hd[k]);
                            chk("hold_err", {31'b0, err[k]}, {31'b0, he[k]});
                        end
                        if (rsp_rdy[k]) begin
                            chk("rsp_rdata", rdata[k], q[k][0].rdata);
                            chk("rsp_err", {31'b0, err[k]}, {31'b0, q[k][0].err});
                            void'(q[k].pop_front());
                        end
                    end
                    held[k] = !rsp_rdy[k];
                    hd[k]   = rdata[k];
                    he[k]   = err[k];
                end else held[k] = 0;
        end
    end

    task automatic send(int k, bit w, bit b, logic [31:0] a, logic [31:0] d);
        bit hs = 0;
        int n = 0;
        req_v[k] = 1; we[k] = w; byt[k] = b; addr[k] = a; wdata[k] = d;
        while (!hs) begin
            @(negedge clk);
            hs = req_rdy[k];
            @(posedge clk);
            #1;
            if (!hs && ++n > 300) begin
                chk("req_timeout", 1, 0);
                break;
            end
        end
        req_v[k] = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain_done", {31'b0, n < 500}, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_stream(int k, int cnt);
        for (int i = 0; i < cnt; i++) begin
            int r = $urandom_range(0, 9);
            bit b = 1'($urandom_range(0, 1));
            logic [31:0] a = 32'h10000 + 32'($urandom_range(0, 15)) * 4;
            if (b) a += 32'($urandom_range(0, 3));
            if (r == 0) begin b = 0; a = a | 32'h1; end
            if (r == 1) a = 32'h20000 + 32'($urandom_range(0, 255));
            if (r == 2) a = 32'hFFFF_FFFC;
            send(k, 1'($urandom_range(0, 1)), b, a, $urandom());
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        bit done = 0;
        int n;
        logic [31:0] old;
        for (int i = 0; i < MSZ + 4; i++) phys[i] = 8'($urandom());
        for (int i = 0; i < MSZ; i++) refm[i] = phys[i];
        for (int k = 0; k < 2; k++) begin addr[k] = '0; wdata[k] = '0; end
        #2 rst_n = 0;
        #20;
        chk("rst_rsp_valid", {30'b0, rsp_v}, 0);
        chk("rst_req_ready", {30'b0, req_rdy}, 0);
        chk("rst_err", {30'b0, err}, 0);
        chk("rst_mem_we", {31'b0, mem_we}, 0);
        chk("rst_mem_mode", {31'b0, mem_mode}, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wd", mem_wd, 0);
        chk("rst_rdata", rdata[0], 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk) #1;

        send(0, 1, 0, 32'h10000, 32'hDEADBEEF);
        send(0, 0, 0, 32'h10000, 0);
        drain();
        chk("t1_mem_word", {phys[32'h10003], phys[32'h10002], phys[32'h10001], phys[32'h10000]}, 32'hDEADBEEF);
        send(1, 0, 1, 32'h10001, 0);
        drain();

        gq.delete();
        fork
            for (int i = 0; i < 4; i++) send(0, 1'(i & 1), 0, 32'h10020 + 32'(i * 4), $urandom());
            for (int i = 0; i < 4; i++) send(1, 1'(~i & 1), 0, 32'h10040 + 32'(i * 4), $urandom());
        join
        drain();
        chk("t3_grant_count", gq.size(), 8);
        for (int i = 0; i < gq.size() && i < 8; i++) chk("t3_grant_order", gq[i], i % 2);

        n = wr_cnt;
        old = {phys[32'h20003], phys[32'h20002], phys[32'h20001], phys[32'h20000]};
        send(0, 0, 0, 32'h10002, 0);
        send(1, 1, 0, 32'h20000, 32'h12345678);
        drain();
        chk("t4_no_mem_cycle", wr_cnt - n, 0);
        chk("t4_mem_unchanged", {phys[32'h20003], phys[32'h20002], phys[32'h20001], phys[32'h20000]}, old);

        rsp_rdy[0] = 0;
        send(0, 0, 0, 32'h10000, 0);
        fork send(1, 0, 0, 32'h10004, 0); join_none
        n = 0;
        while (!rsp_v[0] && n < 20) begin @(negedge clk); n++; end
        chk("t5_rsp_seen", {31'b0, rsp_v[0]}, 1);
        repeat (5) begin
            @(negedge clk);
            chk("t5_rsp_held", {31'b0, rsp_v[0]}, 1);
            chk("t5_r1_stalled", {31'b0, req_rdy[1]}, 0);
        end
        @(posedge clk) #1 rsp_rdy[0] = 1;
        wait fork;
        drain();

        sb_off = 1;
        old = {refm[32'h10008 + 3], refm[32'h10008 + 2], refm[32'h10008 + 1], refm[32'h10008]};
        send(0, 1, 0, 32'h10008, 32'hCAFEF00D);
        @(negedge clk);
        chk("t6_we_in_access", {31'b0, mem_we}, 1);
        #1 rst_n = 0;
        #1;
        chk("t6_we_drops", {31'b0, mem_we}, 0);
        chk("t6_rsp_clear", {30'b0, rsp_v}, 0);
        @(posedge clk) #1;
        chk("t6_word_unchanged", {phys[32'h1000B], phys[32'h1000A], phys[32'h10009], phys[32'h10008]}, old);
        @(negedge clk) rst_n = 1;
        sb_off = 0;
        @(posedge clk) #1;
        send(1, 0, 0, 32'h10008, 0);
        drain();

        fork
            rand_stream(0, 40);
            rand_stream(1, 40);
            while (!done) begin
                @(posedge clk);
                #1 rsp_rdy = 2'($urandom_range(0, 3));
            end
            begin
                #40000;
                done = 1;
            end
        join_any
        wait fork;
        rsp_rdy = 2'b11;
        drain();

        n = 0;
        for (int i = 0; i < MSZ; i++) if (phys[i] !== refm[i]) n++;
        chk("mem_image_diff", n, 0);
        chk("write_count", wr_cnt, exp_wr);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
